// File: rtl/rand_draw_arbiter.sv
// rand_draw_arbiter: shares one 32-bit LFSR among NUM_REQ clients, keeps it seeded,
// and returns each round-robin winner a uniform value in [0, limit) by masking plus rejection.
module rand_draw_arbiter #(
  parameter int          NUM_REQ      = 4,
  parameter int          RANGE_W      = 8,
  parameter int          MAX_TRY      = 4,
  parameter logic [31:0] DEFAULT_SEED = 32'h1BADF00D
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       seed_valid,
  input  logic [31:0]                seed_in,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*RANGE_W-1:0] limit,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       rand_valid,
  output logic [RANGE_W-1:0]         rand_out,
  output logic                       gen_load,
  output logic [31:0]                gen_seed,
  input  logic [31:0]                gen_rand
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TRY_W = $clog2(MAX_TRY + 1);

  localparam logic [2:0] S_INIT = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_SEED = 3'd2;
  localparam logic [2:0] S_DRAW = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   next_idx;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic               seed_pend;
  logic [31:0]        seed_q;
  logic [RANGE_W-1:0] lim_q;
  logic [RANGE_W-1:0] mask;
  logic [RANGE_W-1:0] sample;
  logic [TRY_W-1:0]   tries;

  // Only the low RANGE_W bits of the generator are ever sampled.
  logic unused_gen_bits;
  assign unused_gen_bits = ^gen_rand[31:RANGE_W];

  // Walking offsets downward lets the smallest offset from rr_ptr win without a break.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (req[IDX_W'((int'(rr_ptr) + off) % NUM_REQ)]) begin
        pick_idx   = IDX_W'((int'(rr_ptr) + off) % NUM_REQ);
        pick_found = 1'b1;
      end
    end
  end

  // Smearing (lim_q-1) downward yields 2^ceil(log2(lim_q))-1 for lim_q >= 2.
  always_comb begin
    mask = lim_q - RANGE_W'(1);
    for (int i = RANGE_W - 2; i >= 0; i--) begin
      mask[i] = mask[i] | mask[i+1];
    end
  end

  assign sample   = gen_rand[RANGE_W-1:0] & mask;
  assign next_idx = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);

  // NOTE: sequential state uses non-blocking assignments only, so every branch sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_INIT;
      gnt        <= '0;
      rand_valid <= 1'b0;
      rand_out   <= '0;
      gen_load   <= 1'b0;
      gen_seed   <= DEFAULT_SEED;
      rr_ptr     <= '0;
      idx_q      <= '0;
      seed_pend  <= 1'b0;
      seed_q     <= '0;
      lim_q      <= '0;
      tries      <= '0;
    end else begin
      gen_load   <= 1'b0;
      rand_valid <= 1'b0;

      if (seed_valid) begin
        seed_pend <= 1'b1;
        seed_q    <= seed_in;
      end

      case (state)
        S_INIT: begin
          gen_load <= 1'b1;
          gen_seed <= DEFAULT_SEED;
          state    <= S_IDLE;
        end

        S_IDLE: begin
          if (seed_pend || seed_valid) begin
            state <= S_SEED;
          end else if (pick_found) begin
            gnt   <= NUM_REQ'(1) << pick_idx;
            idx_q <= pick_idx;
            lim_q <= limit[pick_idx*RANGE_W +: RANGE_W];
            tries <= '0;
            state <= S_DRAW;
          end
        end

        S_SEED: begin
          gen_load <= 1'b1;
          gen_seed <= (seed_q == '0) ? DEFAULT_SEED : seed_q;
          // A pulse landing in this very cycle stays pending for the next visit.
          if (!seed_valid) seed_pend <= 1'b0;
          state    <= S_IDLE;
        end

        S_DRAW: begin
          if (!req[idx_q]) begin
            gnt    <= '0;
            rr_ptr <= next_idx;
            state  <= S_IDLE;
          end else if (lim_q <= RANGE_W'(1)) begin
            rand_out   <= '0;
            rand_valid <= 1'b1;
            state      <= S_DONE;
          end else if (sample < lim_q) begin
            rand_out   <= sample;
            rand_valid <= 1'b1;
            state      <= S_DONE;
          end else if (tries == TRY_W'(MAX_TRY)) begin
            // sample <= mask < 2*lim_q, so the fold stays inside [0, lim_q).
            rand_out   <= sample - lim_q;
            rand_valid <= 1'b1;
            state      <= S_DONE;
          end else begin
            tries <= tries + TRY_W'(1);
          end
        end

        S_DONE: begin
          gnt    <= '0;
          rr_ptr <= next_idx;
          state  <= S_IDLE;
        end

        default: state <= S_INIT;
      endcase
    end
  end

endmodule
